// File: rtl/uart_pkg.sv
// uart_pkg: byte type shared by the UART receive and transmit paths
package uart_pkg;
    localparam int UART_BYTE_W = 8;
    typedef logic [UART_BYTE_W-1:0] uart_byte_t;
endpackage

// File: rtl/uart_rx_capture.sv
// uart_rx_capture: turns each rising edge of the receiver ready level into one push strobe
module uart_rx_capture
    import uart_pkg::*;
(
    input  logic       sys_clk,
    input  logic       sys_rstH,
    input  logic       rec_readyH,
    input  uart_byte_t rec_dataH,
    output logic       push_o,
    output uart_byte_t data_o
);
    logic rdy_q, rdy_d, push_q, push_d;
    always_comb begin
        rdy_d  = rec_readyH;
        push_d = rec_readyH & ~rdy_q;
    end
    always_ff @(posedge sys_clk) begin
        if (sys_rstH) begin
            rdy_q  <= 1'b1;
            push_q <= 1'b0;
        end else begin
            rdy_q  <= rdy_d;
            push_q <= push_d;
        end
    end
    assign push_o = push_q;
    assign data_o = rec_dataH;
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead receive FIFO behind the UART receiver with saturating overrun counter
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int OVR_W = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             sys_clk,
    input  logic             sys_rstH,
    input  logic [7:0]       rec_dataH,
    input  logic             rec_readyH,
    output logic [7:0]       rd_dataH,
    output logic             rd_validH,
    input  logic             rd_readyH,
    output logic [AW:0]      fifo_countH,
    output logic             fullH,
    output logic             overrunH,
    input  logic             overrun_clrH,
    output logic [OVR_W-1:0] overrun_cntH
);
    logic             push, pop, wr, drop;
    uart_byte_t       push_byte;
    uart_byte_t       mem_q [DEPTH];
    uart_byte_t       mem_d [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             valid_q, valid_d, full_q, full_d, ovr_q, ovr_d;
    logic [OVR_W-1:0] ovr_cnt_q, ovr_cnt_d;

    uart_rx_capture u_cap (
        .sys_clk   (sys_clk),
        .sys_rstH  (sys_rstH),
        .rec_readyH(rec_readyH),
        .rec_dataH (rec_dataH),
        .push_o    (push),
        .data_o    (push_byte)
    );

    always_comb begin
        pop       = valid_q & rd_readyH;
        wr        = push & (~full_q | pop);
        drop      = push & full_q & ~pop;
        mem_d     = mem_q;
        if (wr) mem_d[wptr_q] = push_byte;
        wptr_d    = wr ? wptr_q + AW'(1) : wptr_q;
        rptr_d    = pop ? rptr_q + AW'(1) : rptr_q;
        count_d   = (wr & ~pop) ? count_q + (AW+1)'(1) : (pop & ~wr) ? count_q - (AW+1)'(1) : count_q;
        valid_d   = count_d != '0;
        full_d    = count_d == (AW+1)'(DEPTH);
        ovr_d     = drop | (ovr_q & ~overrun_clrH);
        ovr_cnt_d = overrun_clrH ? OVR_W'(drop) : (drop && ovr_cnt_q != '1) ? ovr_cnt_q + OVR_W'(1) : ovr_cnt_q;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rstH) begin
            mem_q     <= '{default: '0};
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            full_q    <= 1'b0;
            ovr_q     <= 1'b0;
            ovr_cnt_q <= '0;
        end else begin
            mem_q     <= mem_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            full_q    <= full_d;
            ovr_q     <= ovr_d;
            ovr_cnt_q <= ovr_cnt_d;
        end
    end

    assign rd_dataH     = mem_q[rptr_q];
    assign rd_validH    = valid_q;
    assign fifo_countH  = count_q;
    assign fullH        = full_q;
    assign overrunH     = ovr_q;
    assign overrun_cntH = ovr_cnt_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed stimulus with a queue scoreboard checked by an independent read-port monitor
module tb_uart_rx_fifo;
    logic       sys_clk = 1'b0;
    logic       sys_rstH = 1'b1;
    logic [7:0] rec_dataH = '0;
    logic       rec_readyH = 1'b0;
    logic [7:0] rd_dataH;
    logic       rd_validH;
    logic       rd_readyH = 1'b0;
    logic [4:0] fifo_countH;
    logic       fullH;
    logic       overrunH;
    logic       overrun_clrH = 1'b0;
    logic [7:0] overrun_cntH;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb [$];

    uart_rx_fifo dut (
        .sys_clk     (sys_clk),
        .sys_rstH    (sys_rstH),
        .rec_dataH   (rec_dataH),
        .rec_readyH  (rec_readyH),
        .rd_dataH    (rd_dataH),
        .rd_validH   (rd_validH),
        .rd_readyH   (rd_readyH),
        .fifo_countH (fifo_countH),
        .fullH       (fullH),
        .overrunH    (overrunH),
        .overrun_clrH(overrun_clrH),
        .overrun_cntH(overrun_cntH)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge sys_clk) begin
        if (!sys_rstH && rd_validH && rd_readyH) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: popped %0h with nothing expected", rd_dataH);
            end else begin
                chk("rd_data", int'(rd_dataH), int'(sb.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        rec_readyH = 1'b1;
        rec_dataH  = b;
        tick();
        rec_readyH = 1'b0;
        tick();
    endtask

    task automatic drain();
        int n = 0;
        rd_readyH = 1'b1;
        while (fifo_countH != 0 && n < 100) begin
            tick();
            n++;
        end
        rd_readyH = 1'b0;
        chk("drain_count", int'(fifo_countH), 0);
        chk("drain_sb_empty", sb.size(), 0);
    endtask

    task automatic do_reset();
        sys_rstH = 1'b1;
        tick();
        tick();
        sys_rstH = 1'b0;
        sb.delete();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        chk("rst_count", int'(fifo_countH), 0);
        chk("rst_valid", int'(rd_validH), 0);
        chk("rst_full", int'(fullH), 0);
        chk("rst_ovr", int'(overrunH), 0);
        chk("rst_ovr_cnt", int'(overrun_cntH), 0);

        rec_readyH = 1'b1;
        rec_dataH  = 8'h00;
        tick();
        chk("t1_valid_early", int'(rd_validH), 0);
        rec_dataH = 8'hA5;
        sb.push_back(8'hA5);
        tick();
        chk("t1_valid", int'(rd_validH), 1);
        chk("t1_data", int'(rd_dataH), 8'hA5);
        chk("t1_count", int'(fifo_countH), 1);
        rec_readyH = 1'b0;
        rd_readyH  = 1'b1;
        tick();
        rd_readyH = 1'b0;
        chk("t1_count_pop", int'(fifo_countH), 0);
        chk("t1_sb_empty", sb.size(), 0);

        rec_readyH = 1'b1;
        rec_dataH  = 8'h3C;
        sb.push_back(8'h3C);
        for (int i = 0; i < 20; i++) tick();
        rec_readyH = 1'b0;
        tick();
        chk("t2_hold_count", int'(fifo_countH), 1);
        drain();
        rec_readyH = 1'b1;
        do_reset();
        tick();
        tick();
        chk("t2_rst_hold_count", int'(fifo_countH), 0);
        rec_readyH = 1'b0;
        tick();
        tick();
        chk("t2_rst_fall_count", int'(fifo_countH), 0);

        for (int i = 0; i < 17; i++) begin
            if (i < 16) sb.push_back(8'(i));
            push_byte(8'(i));
        end
        chk("t3_full", int'(fullH), 1);
        chk("t3_count", int'(fifo_countH), 16);
        chk("t3_ovr", int'(overrunH), 1);
        chk("t3_ovr_cnt", int'(overrun_cntH), 1);
        drain();

        overrun_clrH = 1'b1;
        tick();
        overrun_clrH = 1'b0;
        chk("t4_clr", int'(overrunH), 0);
        for (int i = 0; i < 16; i++) begin
            sb.push_back(8'h20 + 8'(i));
            push_byte(8'h20 + 8'(i));
        end
        rec_readyH = 1'b1;
        rec_dataH  = 8'h55;
        sb.push_back(8'h55);
        tick();
        rd_readyH = 1'b1;
        tick();
        rd_readyH  = 1'b0;
        rec_readyH = 1'b0;
        tick();
        chk("t4_count", int'(fifo_countH), 16);
        chk("t4_ovr", int'(overrunH), 0);
        drain();

        for (int i = 0; i < 16; i++) begin
            sb.push_back(8'h60 + 8'(i));
            push_byte(8'h60 + 8'(i));
        end
        for (int i = 0; i < 300; i++) push_byte(8'hEE);
        chk("t5_sat", int'(overrun_cntH), 8'hFF);
        chk("t5_ovr", int'(overrunH), 1);
        rec_readyH = 1'b1;
        rec_dataH  = 8'hEE;
        tick();
        overrun_clrH = 1'b1;
        tick();
        overrun_clrH = 1'b0;
        rec_readyH   = 1'b0;
        chk("t5_clr_drop_ovr", int'(overrunH), 1);
        chk("t5_clr_drop_cnt", int'(overrun_cntH), 1);
        overrun_clrH = 1'b1;
        tick();
        overrun_clrH = 1'b0;
        chk("t5_clr_ovr", int'(overrunH), 0);
        chk("t5_clr_cnt", int'(overrun_cntH), 0);
        chk("t5_count", int'(fifo_countH), 16);
        drain();

        for (int i = 0; i < 7; i++) push_byte(8'h70 + 8'(i));
        chk("t6_count7", int'(fifo_countH), 7);
        rec_readyH = 1'b1;
        rec_dataH  = 8'h77;
        tick();
        sys_rstH   = 1'b1;
        rec_readyH = 1'b0;
        tick();
        chk("t6_rst_count", int'(fifo_countH), 0);
        chk("t6_rst_valid", int'(rd_validH), 0);
        sys_rstH = 1'b0;
        sb.delete();
        tick();
        tick();
        tick();
        chk("t6_post_count", int'(fifo_countH), 0);
        chk("t6_post_valid", int'(rd_validH), 0);
        rd_readyH = 1'b1;
        for (int i = 0; i < 40; i++) begin
            sb.push_back(8'h80 + 8'(i));
            push_byte(8'h80 + 8'(i));
        end
        tick();
        tick();
        rd_readyH = 1'b0;
        chk("t6_wrap_count", int'(fifo_countH), 0);
        chk("t6_wrap_sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
